// File: rtl/mem_pkg.sv
// mem_pkg: shared memory geometry and loader state encoding
package mem_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
  typedef enum logic [1:0] {LOAD, START, WAIT} loader_state_t;
endpackage

// File: rtl/mem_loader.sv
// mem_loader: fills the word memory from a valid/ready stream, then hands off via Start/Done
// Optional running checksum of the loaded block when MEM_LOADER_CHECKSUM_EN is defined.
module mem_loader #(
  parameter int DATA_W = mem_pkg::DATA_W,
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DEPTH  = mem_pkg::DEPTH
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              InValid,
  input  logic [DATA_W-1:0] InData,
  output logic              InReady,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] DataIn,
  output logic              WriteEnable,
  output logic              Start,
  input  logic              Done,
  output logic [DATA_W-1:0] Checksum
);
  import mem_pkg::loader_state_t, mem_pkg::LOAD, mem_pkg::START, mem_pkg::WAIT;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  loader_state_t state;
  logic [ADDR_W-1:0] count;
  logic done_q;
  logic accept, last, rise;
  assign accept = (state == LOAD) && InValid && InReady;
  assign last   = count == LAST;
  assign rise   = Done && !done_q;
  // Fill FSM: write one word per accept, pulse Start after the block, wait for a fresh Done rise
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state       <= LOAD;
      count       <= '0;
      InReady     <= 1'b1;
      WriteEnable <= 1'b0;
      Address     <= '0;
      DataIn      <= '0;
      Start       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= Done;
      WriteEnable <= accept;
      Start       <= (state == START) && !Start;
      if (accept) begin
        Address <= count;
        DataIn  <= InData;
        count   <= last ? '0 : count + 1'b1;
      end
      if (accept && last) begin
        state   <= START;
        InReady <= 1'b0;
      end else if (state == START && Start) begin
        state <= WAIT;
      end else if (state == WAIT && rise) begin
        state   <= LOAD;
        InReady <= 1'b1;
      end
    end
  end
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  // Block checksum: add each accepted word, clear when a new block is released
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) sum <= '0;
    else if (accept) sum <= sum + InData;
    else if (state == WAIT && rise) sum <= '0;
  end
  assign Checksum = sum;
`else
  assign Checksum = '0;
`endif
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed checks of the block loader handshake, write stream and checksum
module tb_mem_loader;
`ifdef MEM_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif
  logic        Clock, Reset, InValid, InReady, WriteEnable, Start, Done;
  logic [15:0] InData, DataIn, Checksum;
  logic [4:0]  Address;
  int tests = 0, fails = 0;
  int wr_total = 0, start_cnt = 0, gaps = 0;
  logic [4:0] exp_addr;

  mem_loader dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InData(InData),
    .InReady(InReady), .Address(Address), .DataIn(DataIn),
    .WriteEnable(WriteEnable), .Start(Start), .Done(Done), .Checksum(Checksum)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Write-stream observer: addresses must run contiguously from 0 after every reset
  always @(posedge Clock or negedge Reset) begin
    if (!Reset) exp_addr <= '0;
    else if (WriteEnable) begin
      if (Address != exp_addr) gaps <= gaps + 1;
      exp_addr <= Address + 5'd1;
    end
  end
  always @(posedge Clock) begin
    if (Reset && WriteEnable) wr_total <= wr_total + 1;
    if (Reset && Start) start_cnt <= start_cnt + 1;
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_block(input logic [15:0] base, input logic [15:0] inc);
    for (int i = 0; i < 32; i++) begin
      InValid = 1'b1;
      InData  = base + 16'(i) * inc;
      tick();
    end
    InValid = 1'b0;
  endtask

  task automatic release_block();
    tick();
    chk("start_pulse", Start, 1);
    tick();
    chk("start_low", Start, 0);
    Done = 1'b0;
    tick();
    chk("wait_ready_low", InReady, 0);
    Done = 1'b1;
    tick();
    chk("ready_after_rise", InReady, 1);
  endtask

  initial begin
    Reset = 1'b0; InValid = 1'b0; InData = '0; Done = 1'b0;
    #12;
    chk("rst_inready", InReady, 1);
    chk("rst_we", WriteEnable, 0);
    chk("rst_addr", Address, 0);
    chk("rst_data", DataIn, 0);
    chk("rst_start", Start, 0);
    chk("rst_cksum", Checksum, 0);
    @(negedge Clock);
    Reset = 1'b1;
    tick();
    // block 1: back-to-back words 1..32
    for (int i = 1; i <= 32; i++) begin
      InValid = 1'b1;
      InData  = 16'(i);
      tick();
      chk("b1_we", WriteEnable, 1);
      chk("b1_addr", Address, i - 1);
      chk("b1_data", DataIn, i);
    end
    chk("b1_ready_drop", InReady, 0);
    InValid = 1'b0;
    tick();
    chk("b1_start", Start, 1);
    chk("b1_we_off", WriteEnable, 0);
    tick();
    chk("b1_start_once", Start, 0);
    chk("b1_cksum", Checksum, CK_EN ? 32'h0210 : 32'h0);
    chk("b1_writes", wr_total, 32);
    // offered words during WAIT are ignored
    InValid = 1'b1;
    InData  = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_no_we", WriteEnable, 0);
      chk("wait_no_ready", InReady, 0);
    end
    chk("wait_no_write", wr_total, 32);
    Done = 1'b1;
    tick();
    chk("b1_return", InReady, 1);
    chk("b1_cksum_clr", Checksum, 0);
    InValid = 1'b0;
    // block 2: InValid toggling, Done held high throughout
    for (int k = 0; k < 64; k++) begin
      InValid = (k % 2) == 0;
      InData  = 16'h0100 + 16'(k / 2);
      tick();
      if ((k % 2) == 0) begin
        chk("b2_we", WriteEnable, 1);
        chk("b2_addr", Address, k / 2);
      end else if (k < 63) begin
        chk("b2_we_gap", WriteEnable, 0);
      end
      if (k == 62) chk("b2_ready_drop", InReady, 0);
    end
    chk("b2_start", Start, 1);
    tick();
    chk("b2_cksum", Checksum, CK_EN ? 32'h21F0 : 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b2_held_done", InReady, 0);
    end
    Done = 1'b0;
    tick();
    chk("b2_done_low", InReady, 0);
    Done = 1'b1;
    tick();
    chk("b2_return", InReady, 1);
    // block 3: all-ones wrap, then ones to show clearing between blocks
    send_block(16'hFFFF, 16'h0000);
    chk("b3_ready_drop", InReady, 0);
    chk("b3_cksum", Checksum, CK_EN ? 32'hFFE0 : 32'h0);
    release_block();
    send_block(16'h0001, 16'h0000);
    chk("b4_cksum", Checksum, CK_EN ? 32'h0020 : 32'h0);
    release_block();
    chk("blocks_started", start_cnt, 4);
    // asynchronous reset mid-block
    for (int i = 0; i < 10; i++) begin
      InValid = 1'b1;
      InData  = 16'h0050 + 16'(i);
      tick();
    end
    chk("mid_we", WriteEnable, 1);
    chk("mid_addr", Address, 9);
    InValid = 1'b0;
    #2 Reset = 1'b0;
    #1;
    chk("arst_we", WriteEnable, 0);
    chk("arst_addr", Address, 0);
    chk("arst_data", DataIn, 0);
    chk("arst_ready", InReady, 1);
    chk("arst_cksum", Checksum, 0);
    tick();
    Reset = 1'b1;
    InValid = 1'b1;
    InData  = 16'h0077;
    tick();
    chk("post_rst_addr", Address, 0);
    chk("post_rst_data", DataIn, 16'h0077);
    InValid = 1'b0;
    tick();
    chk("total_writes", wr_total, 138);
    chk("addr_gaps", gaps, 0);
    chk("starts_final", start_cnt, 4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
